// File: rtl/refresh_sequencer.sv
// refresh_sequencer
//   Services a maintenance request from the command queue. It fences user
//   traffic, precharges all banks if any are open, waits tRP, issues REFRESH,
//   and waits tRFC. It then pulses cmd_issued back to the queue.
//   The DDR command slot is driven only while a sequence is in flight.
//   Optional feature macro: REFRESH_BURST_EN. When it is defined, each request
//   issues BURST_LEN REFRESH commands, and each one is followed by a full tRFC wait.
//   Every output comes from a flop. The flops are loaded from the decode of
//   the next state, so each output lines up with the state it belongs to.

module refresh_sequencer #(
  parameter int NUM_BANKS = 8,
  parameter int T_RP      = 3,
  parameter int T_RFC     = 26,
  parameter int BURST_LEN = 2
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 maint_req,
  input  logic                 user_busy,
  input  logic [NUM_BANKS-1:0] bank_open,
  output logic                 hold_user,
  output logic                 ddr_cmd_valid,
  output logic [2:0]           ddr_cmd,
  output logic                 cmd_issued,
  output logic                 refresh_busy
);

  localparam int T_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int CNT_W = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] TRP_LOAD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] TRFC_LOAD = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] CMD_NOP  = 3'b000;
  localparam logic [2:0] CMD_PREA = 3'b010;
  localparam logic [2:0] CMD_REF  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_PREA,
    S_TRP,
    S_REF,
    S_TRFC,
    S_DONE
  } state_t;

  // Refuse to elaborate with timing parameters that would leave no wait state.
  if (T_RP < 1 || T_RFC < 1 || BURST_LEN < 1 || NUM_BANKS < 1) begin : g_bad_cfg
    $error("refresh_sequencer: T_RP, T_RFC, BURST_LEN and NUM_BANKS must all be >= 1");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             more_in_ref;   // another REF is due right after this REF (T_RFC==1 case)
  logic             more_in_trfc;  // another REF is due when this tRFC wait ends

`ifdef REFRESH_BURST_EN
  localparam int BURST_W = $clog2(BURST_LEN + 1);
  localparam logic [BURST_W-1:0] BURST_LOAD = BURST_W'(BURST_LEN);

  // Remaining REFRESH commands for the current request; decremented by each REF.
  logic [BURST_W-1:0] burst_cnt, burst_nxt;

  assign more_in_ref  = (burst_cnt > BURST_W'(1));
  assign more_in_trfc = (burst_cnt != '0);
`else
  assign more_in_ref  = 1'b0;
  assign more_in_trfc = 1'b0;
`endif

  // State register: sequencer state and the tRP/tRFC wait counter.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so the reset branch sits inside
    // the edge-triggered block and n_rst is absent from the sensitivity list.
    if (!n_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
`ifdef REFRESH_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      // NOTE: flops use non-blocking assignment so that every register
      // samples the pre-edge values, whatever order the statements run in.
      state     <= state_nxt;
      cnt       <= cnt_nxt;
`ifdef REFRESH_BURST_EN
      burst_cnt <= burst_nxt;
`endif
    end
  end

  // Next-state logic: walks the drain / precharge / refresh sequence.
  always_comb begin
    // NOTE: every signal gets a default here. Any path that did not assign it
    // would otherwise have to hold its old value, and that infers a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef REFRESH_BURST_EN
    burst_nxt = burst_cnt;
`endif
    unique case (state)
      S_IDLE: begin
        if (maint_req) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // bank_open matters only at the exit decision. A closed device skips PREA.
        if (!user_busy) begin
`ifdef REFRESH_BURST_EN
          burst_nxt = BURST_LOAD;
`endif
          state_nxt = (|bank_open) ? S_PREA : S_REF;
        end
      end
      S_PREA: begin
        // The wait is T_RP-1 counter cycles, so REF lands exactly T_RP after PREA.
        cnt_nxt   = TRP_LOAD;
        state_nxt = (T_RP == 1) ? S_REF : S_TRP;
      end
      S_TRP: begin
        if (cnt <= CNT_ONE) begin
          cnt_nxt   = '0;
          state_nxt = S_REF;
        end else begin
          cnt_nxt   = cnt - CNT_ONE;
        end
      end
      S_REF: begin
`ifdef REFRESH_BURST_EN
        burst_nxt = burst_cnt - BURST_W'(1);
`endif
        cnt_nxt   = TRFC_LOAD;
        if (T_RFC == 1) state_nxt = more_in_ref ? S_REF : S_DONE;
        else            state_nxt = S_TRFC;
      end
      S_TRFC: begin
        if (cnt <= CNT_ONE) begin
          cnt_nxt   = '0;
          state_nxt = more_in_trfc ? S_REF : S_DONE;
        end else begin
          cnt_nxt   = cnt - CNT_ONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: derived from the next state so that registering it aligns
  // each output with the state it belongs to.
  logic       hold_user_d;
  logic       ddr_cmd_valid_d;
  logic [2:0] ddr_cmd_d;
  logic       cmd_issued_d;
  logic       refresh_busy_d;

  always_comb begin
    hold_user_d     = (state_nxt != S_IDLE);
    refresh_busy_d  = (state_nxt != S_IDLE);
    ddr_cmd_valid_d = 1'b0;
    ddr_cmd_d       = CMD_NOP;
    cmd_issued_d    = 1'b0;
    unique case (state_nxt)
      S_PREA: begin
        ddr_cmd_valid_d = 1'b1;
        ddr_cmd_d       = CMD_PREA;
      end
      S_REF: begin
        ddr_cmd_valid_d = 1'b1;
        ddr_cmd_d       = CMD_REF;
      end
      S_DONE: begin
        cmd_issued_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Output register: every output is a flop and clears on reset, so an
  // aborted sequence never leaks a command or a cmd_issued pulse.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hold_user     <= 1'b0;
      ddr_cmd_valid <= 1'b0;
      ddr_cmd       <= CMD_NOP;
      cmd_issued    <= 1'b0;
      refresh_busy  <= 1'b0;
    end else begin
      hold_user     <= hold_user_d;
      ddr_cmd_valid <= ddr_cmd_valid_d;
      ddr_cmd       <= ddr_cmd_d;
      cmd_issued    <= cmd_issued_d;
      refresh_busy  <= refresh_busy_d;
    end
  end

endmodule

// File: tb/tb_refresh_sequencer.sv
// tb_refresh_sequencer
//   Randomized scoreboard bench for refresh_sequencer. The stimulus task works
//   out, from the timing rules, the clock edge at which each command and the
//   completion pulse must appear, and pushes those events into a queue. A
//   separate monitor pops an event whenever the DUT shows one and compares it.
//   The monitor also checks the busy/hold window on every cycle.
//   Define REFRESH_BURST_EN here as well as in the RTL when building the burst variant.

module tb_refresh_sequencer;

  localparam int NUM_BANKS = 8;
  localparam int T_RP      = 3;
  localparam int T_RFC     = 26;
  localparam int BURST_LEN = 2;
`ifdef REFRESH_BURST_EN
  localparam int NREF = BURST_LEN;
`else
  localparam int NREF = 1;
`endif

  localparam logic [2:0] K_PREA = 3'b010;
  localparam logic [2:0] K_REF  = 3'b001;
  localparam logic [2:0] K_DONE = 3'b111;

  logic                 clk;
  logic                 n_rst;
  logic                 maint_req;
  logic                 user_busy;
  logic [NUM_BANKS-1:0] bank_open;
  logic                 hold_user;
  logic                 ddr_cmd_valid;
  logic [2:0]           ddr_cmd;
  logic                 cmd_issued;
  logic                 refresh_busy;

  refresh_sequencer #(
    .NUM_BANKS (NUM_BANKS),
    .T_RP      (T_RP),
    .T_RFC     (T_RFC),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .maint_req     (maint_req),
    .user_busy     (user_busy),
    .bank_open     (bank_open),
    .hold_user     (hold_user),
    .ddr_cmd_valid (ddr_cmd_valid),
    .ddr_cmd       (ddr_cmd),
    .cmd_issued    (cmd_issued),
    .refresh_busy  (refresh_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc is the number of rising edges seen. After edge k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] kind;
    int         at;
  } evt_t;

  evt_t exp_q[$];
  int   n_vec  = 0;
  int   n_mis  = 0;
  int   win_lo = 1;   // busy window, inclusive edge numbers
  int   win_hi = 0;
  logic exp_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares the busy window on every cycle and pops one expected
  // event whenever a command or completion pulse shows up.
  initial begin
    forever begin
      logic [2:0] obs;
      evt_t       e;
      @(posedge clk);
      #1;
      exp_busy = (cyc >= win_lo) && (cyc <= win_hi);
      check("hold_user", 32'(hold_user), 32'(exp_busy));
      check("refresh_busy", 32'(refresh_busy), 32'(exp_busy));
      if (!ddr_cmd_valid) check("ddr_cmd_nop", 32'(ddr_cmd), 32'd0);
      if (ddr_cmd_valid || cmd_issued) begin
        obs = cmd_issued ? (ddr_cmd_valid ? 3'b110 : K_DONE) : ddr_cmd;
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'(obs), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 32'(obs), 32'(e.kind));
          check("event_edge", 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  // Issues one request. d is the number of edges user_busy is held from the
  // request edge. The expected timeline comes straight from the timing rules.
  task automatic run_req(input int d, input logic [NUM_BANKS-1:0] banks, input bit drop_early);
    int p, e, r, done, t;
    @(negedge clk);
    p = cyc + 1;
    maint_req = 1'b1;
    user_busy = (d > 0);
    bank_open = banks;
    e = (d > 1) ? p + d : p + 1;         // edge at which DRAIN exits
    r = (banks != '0) ? e + T_RP : e;    // first REFRESH edge
    if (banks != '0) exp_q.push_back('{K_PREA, e});
    for (int i = 0; i < NREF; i++) exp_q.push_back('{K_REF, r + i * T_RFC});
    done = r + NREF * T_RFC;
    exp_q.push_back('{K_DONE, done});
    win_lo = p;
    win_hi = done;
    if (d > 0) begin
      repeat (d) @(negedge clk);
      user_busy = 1'b0;
    end
    while (cyc < e) @(negedge clk);
    // Past the drain exit, these inputs must no longer matter.
    bank_open = NUM_BANKS'($urandom);
    user_busy = 1'($urandom);
    if (drop_early) maint_req = 1'b0;
    t = 0;
    while (!cmd_issued && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("cmd_issued_seen", 32'(cmd_issued), 32'd1);
    maint_req = 1'b0;
    user_busy = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  // Asserts reset in the middle of the tRFC wait. Everything must clear at
  // once, and no completion pulse may follow.
  task automatic run_mid_reset();
    int p, r;
    @(negedge clk);
    p = cyc + 1;
    maint_req = 1'b1;
    user_busy = 1'b0;
    bank_open = '0;
    r = p + 1;
    exp_q.push_back('{K_REF, r});
    win_lo = p;
    win_hi = r + NREF * T_RFC;
    while (cyc < r + 5) @(negedge clk);
    n_rst     = 1'b0;
    maint_req = 1'b0;
    exp_q.delete();
    win_hi = cyc;
    @(negedge clk);
    check("rst_mid_hold_user", 32'(hold_user), 32'd0);
    check("rst_mid_cmd_valid", 32'(ddr_cmd_valid), 32'd0);
    check("rst_mid_cmd", 32'(ddr_cmd), 32'd0);
    check("rst_mid_cmd_issued", 32'(cmd_issued), 32'd0);
    check("rst_mid_busy", 32'(refresh_busy), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (NREF * T_RFC + 5) @(negedge clk);
  endtask

  initial begin
    n_rst     = 1'b0;
    maint_req = 1'b0;
    user_busy = 1'b0;
    bank_open = '0;
    repeat (2) @(negedge clk);
    check("rst_hold_user", 32'(hold_user), 32'd0);
    check("rst_cmd_valid", 32'(ddr_cmd_valid), 32'd0);
    check("rst_cmd", 32'(ddr_cmd), 32'd0);
    check("rst_cmd_issued", 32'(cmd_issued), 32'd0);
    check("rst_busy", 32'(refresh_busy), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    run_req(0, 8'h05, 1'b0);          // idle request with open banks
    run_req(10, 8'h81, 1'b0);         // long drain
    run_req(0, 8'h00, 1'b0);          // nothing open: PREA skipped
    run_req(3, 8'h00, 1'b1);          // drain, no banks, request dropped early
    run_mid_reset();
    for (int i = 0; i < 16; i++) begin
      logic [NUM_BANKS-1:0] b;
      b = ($urandom_range(0, 3) == 0) ? '0 : NUM_BANKS'($urandom);
      run_req($urandom_range(0, 6), b, 1'($urandom));
    end
    run_req(1, 8'hff, 1'b0);          // busy only on the request edge

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
